// File: rtl/mux_a_arbiter.sv
// mux_a_arbiter: round-robin req/gnt arbiter owning the 4-channel A-side mux select,
// with one idle turnaround cycle between owners and optional hold-time preemption.
module mux_a_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] s,
    output logic       busy,
    output logic       preempt
);
    localparam logic IDLE = 1'b0;
    localparam logic OWN  = 1'b1;
    localparam logic [7:0] LIM = 8'(MAX_HOLD - 1);

    logic       state;
    logic [1:0] owner, last, winner;
    logic [7:0] hold_cnt;
    logic       others, pre;

    // Scan downwards so the channel closest after last wins.
    always_comb begin
        winner = last;
        for (int k = 4; k >= 1; k--)
            if (req[last + 2'(k)]) winner = last + 2'(k);
    end

    assign others = |(req & ~(4'b0001 << owner));
    // >= rather than == so a saturated counter still preempts when contention appears late.
    assign pre = (MAX_HOLD != 0) && (hold_cnt >= LIM) && req[owner] && others;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            s        <= 2'b00;
            busy     <= 1'b0;
            preempt  <= 1'b0;
            owner    <= 2'd0;
            last     <= 2'd3;
            hold_cnt <= 8'd0;
        end else begin
            preempt <= 1'b0;
            if (state == IDLE) begin
                if (en && |req) begin
                    owner    <= winner;
                    s        <= winner;
                    gnt      <= 4'b0001 << winner;
                    busy     <= 1'b1;
                    hold_cnt <= 8'd0;
                    state    <= OWN;
                end
            end else if (!req[owner] || pre) begin
                gnt     <= 4'b0000;
                busy    <= 1'b0;
                last    <= owner;
                state   <= IDLE;
                preempt <= req[owner];
            end else if (hold_cnt != 8'hFF) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mux_a_arbiter.sv
// tb_mux_a_arbiter: scenario tasks push expected {gnt,s,busy,preempt} per cycle to a
// scoreboard queue and pop/compare after each clock edge.
module tb_mux_a_arbiter;
    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       en = 1'b1;
    logic [3:0] req = 4'b1111;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       busy, preempt;

    logic [7:0] sb[$];
    logic [7:0] got, exp;
    int n_chk = 0;
    int n_pass = 0;

    mux_a_arbiter #(.MAX_HOLD(4)) dut (
        .clk(clk), .n_reset(n_reset), .en(en), .req(req),
        .gnt(gnt), .s(s), .busy(busy), .preempt(preempt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pk(input logic [3:0] g, input logic [1:0] sl, input logic p);
        return {g, sl, |g, p};
    endfunction

    task automatic tick(input logic [3:0] r, input logic e, input logic [7:0] x);
        req = r;
        en = e;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        req = 4'b0000;
        en = 1'b1;
        @(posedge clk);
        #1;
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        req = 4'b1111;
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(pk(4'b0000, 2'd0, 1'b0));
        got = {gnt, s, busy, preempt};
        exp = sb.pop_front();
        n_chk++;
        if (got !== exp) $display("FAIL reset_hold got %b exp %b", got, exp);
        else n_pass++;
        n_reset = 1'b1;
        tick(4'b1111, 1'b1, pk(4'b0001, 2'd0, 1'b0));
        got = {gnt, s, busy, preempt};
        exp = sb.pop_front();
        n_chk++;
        if (got !== exp) $display("FAIL reset_first_grant got %b exp %b", got, exp);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [3:0] r[17] = '{4'hF, 4'hF, 4'hF, 4'hE, 4'hF, 4'hF, 4'hF, 4'hD, 4'hF,
                              4'hF, 4'hF, 4'hB, 4'hF, 4'hF, 4'hF, 4'h7, 4'hF};
        logic [3:0] g[17] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h4,
                              4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1};
        logic [1:0] sl[17] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
        do_reset();
        for (int i = 0; i < 17; i++) begin
            tick(r[i], 1'b1, pk(g[i], sl[i], 1'b0));
            got = {gnt, s, busy, preempt};
            exp = sb.pop_front();
            n_chk++;
            if (got !== exp) $display("FAIL round_robin[%0d] got %b exp %b", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_preemption();
        logic [3:0] r[6] = '{4'h4, 4'h6, 4'h6, 4'h6, 4'h6, 4'h6};
        logic [3:0] g[6] = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h2};
        logic [1:0] sl[6] = '{2, 2, 2, 2, 2, 1};
        logic       p[6] = '{0, 0, 0, 0, 1, 0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(r[i], 1'b1, pk(g[i], sl[i], p[i]));
            got = {gnt, s, busy, preempt};
            exp = sb.pop_front();
            n_chk++;
            if (got !== exp) $display("FAIL preemption[%0d] got %b exp %b", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_no_contention();
        do_reset();
        for (int i = 0; i < 303; i++) begin
            if (i < 301) tick(4'b1000, 1'b1, pk(4'b1000, 2'd3, 1'b0));
            else if (i == 301) tick(4'b1001, 1'b1, pk(4'b0000, 2'd3, 1'b1));
            else tick(4'b1001, 1'b1, pk(4'b0001, 2'd0, 1'b0));
            got = {gnt, s, busy, preempt};
            exp = sb.pop_front();
            n_chk++;
            if (got !== exp) $display("FAIL no_contention[%0d] got %b exp %b", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] r[6] = '{4'h4, 4'h6, 4'h6, 4'h6, 4'h2, 4'h2};
        logic [3:0] g[6] = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h2};
        logic [1:0] sl[6] = '{2, 2, 2, 2, 2, 1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(r[i], 1'b1, pk(g[i], sl[i], 1'b0));
            got = {gnt, s, busy, preempt};
            exp = sb.pop_front();
            n_chk++;
            if (got !== exp) $display("FAIL simultaneous[%0d] got %b exp %b", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_en_reset();
        logic       e[5] = '{0, 0, 1, 0, 0};
        logic [3:0] g[5] = '{4'h0, 4'h0, 4'h4, 4'h4, 4'h4};
        logic [1:0] sl[5] = '{0, 0, 2, 2, 2};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(4'b0100, e[i], pk(g[i], sl[i], 1'b0));
            got = {gnt, s, busy, preempt};
            exp = sb.pop_front();
            n_chk++;
            if (got !== exp) $display("FAIL en_gating[%0d] got %b exp %b", i, got, exp);
            else n_pass++;
        end
        n_reset = 1'b0;
        #1;
        sb.push_back(pk(4'b0000, 2'd0, 1'b0));
        got = {gnt, s, busy, preempt};
        exp = sb.pop_front();
        n_chk++;
        if (got !== exp) $display("FAIL async_reset got %b exp %b", got, exp);
        else n_pass++;
        #2;
        n_reset = 1'b1;
        tick(4'b0100, 1'b0, pk(4'b0000, 2'd0, 1'b0));
        got = {gnt, s, busy, preempt};
        exp = sb.pop_front();
        n_chk++;
        if (got !== exp) $display("FAIL post_reset_en_off got %b exp %b", got, exp);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_preemption();
        test_no_contention();
        test_simultaneous();
        test_en_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mux_a_arbiter.md
# mux_a_arbiter

Round-robin bus arbiter that shares the 4-channel 8-bit A-side multiplexer between four requesters (channels A, B, C, D = requesters 0..3). It owns the mux select, grants the bus to one requester at a time through a req/gnt handshake, inserts a one-cycle turnaround between owners, and optionally preempts an owner that holds the bus too long while others wait. It sits between the CPU sequencer/peripherals that drive the mux inputs and the mux select input.

## Interface

- MAX_HOLD, 16: maximum consecutive grant cycles before preemption, range 0..255; 0 disables preemption.

- CLK  input  1  system clock, rising edge.
- N_RESET  input  1  asynchronous active-low reset.
- EN  input  1  arbitration enable; gates new grants only.
- REQ  input  4  request per channel, level, bit i = channel i.
- GNT  output  4  one-hot grant, registered; all zero when idle.
- S  output  2  mux select, registered; encodes current or last owner.
- BUSY  output  1  high while any GNT bit is high.
- PREEMPT  output  1  one-cycle pulse when a grant is withdrawn by preemption.

## Operation

- One clock (CLK), asynchronous active-low reset (N_RESET); all outputs are registers.
- Internal state: fsm {IDLE, OWN}, owner[1:0], last[1:0] (round-robin pointer), hold_cnt[7:0].
- Reset values: fsm=IDLE, GNT=4'b0000, S=2'b00, BUSY=0, PREEMPT=0, owner=0, last=3 (so channel 0 has top priority after reset), hold_cnt=0.
- IDLE: if EN=1 and REQ!=0, pick first set bit scanning last+1, last+2, last+3, last (mod 4); next edge: owner=winner, S=winner, GNT[winner]=1, BUSY=1, hold_cnt=0, fsm=OWN. Otherwise stay IDLE; S holds previous value.
- OWN, release: REQ[owner]=0 sampled → next edge GNT=0, BUSY=0, last=owner, fsm=IDLE.
- OWN, preemption (MAX_HOLD!=0): hold_cnt==MAX_HOLD-1 and REQ[owner]=1 and (REQ & ~onehot(owner))!=0 → next edge GNT=0, BUSY=0, last=owner, PREEMPT=1 for one cycle, fsm=IDLE.
- OWN, otherwise: hold_cnt increments, saturating at 255; GNT/S unchanged.
- Release and preemption in the same cycle: treated as release, PREEMPT stays 0.
- MAX_HOLD reached with no other requester: no preemption; owner keeps the bus, hold_cnt saturates, preemption fires as soon as another request appears.
- EN=0 never removes an existing grant; it only blocks the IDLE→OWN transition.
- Requests from non-owners during OWN are ignored until IDLE; a preempted requester keeping REQ high gets lowest priority in the next arbitration.
- REQ changes on the winner's line in the arbitration cycle are not re-checked: the grant is issued on the sampled value.

## Timing

- Grant latency: REQ sampled high in IDLE at edge n → GNT and S valid after edge n (one cycle).
- Release latency: REQ[owner] sampled low at edge n → GNT=0 after edge n.
- Turnaround: at least one full IDLE cycle with GNT=0 between any two owners; back-to-back ownership by different channels is never possible.
- Minimum grant length: 1 cycle. Maximum with contention: exactly MAX_HOLD cycles of GNT high.
- S changes only on the IDLE→OWN edge, so the mux output is stable for the whole grant.
- Reset asserted mid-grant: all outputs return to reset values immediately (asynchronous), no PREEMPT pulse.

## Test plan

- Reset: N_RESET low with REQ=4'b1111 → GNT=0, S=0, BUSY=0, PREEMPT=0; after release, first grant GNT=4'b0001, S=0 one cycle later.
- Round-robin fairness: REQ=4'b1111 held, each owner drops REQ for one cycle after 3 grant cycles → grant order 0,1,2,3,0 with one idle cycle between each, S=0,1,2,3,0.
- Preemption: MAX_HOLD=4, REQ[2] held, REQ[1] asserted → GNT[2] high exactly 4 cycles, PREEMPT pulse one cycle, one idle cycle, then GNT=4'b0010, S=1.
- No contention: MAX_HOLD=4, only REQ[3] held for 300 cycles → GNT=4'b1000 continuous, PREEMPT never pulses; REQ[0] raised at cycle 300 → preemption next edge.
- Simultaneous release/preempt: owner drops REQ in the cycle hold_cnt==MAX_HOLD-1 with another request pending → GNT drops, PREEMPT=0.
- EN gating and async reset: EN=0 with REQ=4'b0100 → no grant; EN=1 → GNT=4'b0100 next cycle; EN=0 mid-grant keeps grant; N_RESET pulse mid-grant → GNT=0 immediately.
